// File: rtl/cgra_cfg_pkg.sv
// Purpose: shared state encoding, default chain geometry and word-count helper for the config loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cgra_cfg_pkg;

  localparam int CHAIN_LEN_DEF = 46;
  localparam int WORD_W_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } cfg_state_t;

  // Number of host words needed to cover the whole chain (ceiling division).
  function automatic int words_required(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// Purpose: parallel-load, serial-out shift register feeding the config chain, LSB first.
// Latency: loaded word's bit 0 is on ser_out the cycle after load.
// Backpressure: none; the controller decides when to load and when to shift.
module cfg_piso #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_dat,
  output logic              ser_out
);

  logic [WORD_W-1:0] sr;

  // Load has priority over shift; shifting moves the next bit into position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_dat;
    end else if (shift) begin
      sr <= sr >> 1;
    end
  end

  assign ser_out = sr[0];

endmodule

// File: rtl/config_chain_loader.sv
// Purpose: loads a host bitstream into a scan-style config chain, then recirculates it once to compare ones counts.
// Latency: 2*CHAIN_LEN shift cycles plus fetch/done overhead per pass; done pulses one cycle after the last verify bit.
// Backpressure: word_ready only in FETCH; the chain simply pauses (shift enable low) while the host withholds a word.
module config_chain_loader
  import cgra_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_in,
  output logic              chain_shift_en,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);

  cfg_state_t       state;
  cfg_state_t       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] ones_load;
  logic [CNT_W-1:0] ones_verify;
  logic [WB_W-1:0]  word_bit_cnt;
  logic             piso_load;
  logic             piso_shift;
  logic             piso_bit;
  logic             last_bit;
  logic             word_end;

  // Final chain bit of the current phase, and final bit of the current word.
  assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_end = (word_bit_cnt == WB_W'(WORD_W - 1));

  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk      (Config_Clock),
    .rst_n    (Config_Reset),
    .load     (piso_load),
    .shift    (piso_shift),
    .load_dat (word_data),
    .ser_out  (piso_bit)
  );

  // State register.
  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and outputs; all outputs decode from state so reset clears them at once.
  always_comb begin
    state_nxt      = state;
    word_ready     = 1'b0;
    chain_shift_en = 1'b0;
    chain_in       = 1'b0;
    piso_load      = 1'b0;
    piso_shift     = 1'b0;
    busy           = (state != ST_IDLE);
    done           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          piso_load = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        chain_shift_en = 1'b1;
        chain_in       = piso_bit;
        piso_shift     = 1'b1;
        // Chain end wins over word end, so unused bits of the last word are dropped.
        if (last_bit)      state_nxt = ST_VERIFY;
        else if (word_end) state_nxt = ST_FETCH;
      end
      ST_VERIFY: begin
        chain_shift_en = 1'b1;
        chain_in       = chain_out;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit/word counters, load and verify ones counters, and the sticky mismatch flag.
  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      bit_cnt      <= '0;
      word_bit_cnt <= '0;
      ones_load    <= '0;
      ones_verify  <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bit_cnt      <= '0;
            word_bit_cnt <= '0;
            ones_load    <= '0;
            ones_verify  <= '0;
            err          <= 1'b0;
          end
        end
        ST_SHIFT: begin
          ones_load    <= ones_load + CNT_W'(chain_in);
          bit_cnt      <= last_bit ? '0 : bit_cnt + CNT_W'(1);
          word_bit_cnt <= word_end ? '0 : word_bit_cnt + WB_W'(1);
        end
        ST_VERIFY: begin
          ones_verify <= ones_verify + CNT_W'(chain_out);
          bit_cnt     <= last_bit ? '0 : bit_cnt + CNT_W'(1);
          if (last_bit) begin
            err <= (ones_load != (ones_verify + CNT_W'(chain_out)));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/config_chain_loader.md
CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 46, SHALL be the total bit length of the downstream ConfigIn/ConfigOut scan chain.
REQ-002 Parameter WORD_W, default 32, SHALL be the width of bitstream words accepted from the host.
REQ-003 Config_Clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Config_Reset  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start  in  1  SHALL request a load-and-verify pass (pulse, sampled in IDLE only).
REQ-006 word_data  in  WORD_W  SHALL carry bitstream bits, LSB shifted first.
REQ-007 word_valid  in  1 / word_ready  out  1  SHALL form a valid/ready handshake; transfer when both are high on a clock edge.
REQ-008 chain_in  out  1  SHALL drive ConfigIn of the first cell of the chain.
REQ-009 chain_shift_en  out  1  SHALL be the chain shift enable; the chain advances one bit per cycle while it is high.
REQ-010 chain_out  in  1  SHALL be the ConfigOut of the last cell of the chain.
REQ-011 busy  out  1  SHALL be high in every state except IDLE.
REQ-012 done  out  1  SHALL be a one-cycle pulse at the end of a pass.
REQ-013 err  out  1  SHALL be the verify-mismatch flag, valid with done and held until the next start.

Function
REQ-014 States SHALL be IDLE, FETCH, SHIFT, VERIFY and DONE.
REQ-015 IDLE: start=1 -> FETCH; clear bit counter, ones counter and err.
REQ-016 FETCH: word_ready=1; on handshake, load the word into the PISO -> SHIFT; word_valid low -> stay, chain_shift_en=0.
REQ-017 SHIFT: chain_shift_en=1; chain_in=PISO bit 0; PISO shifts right; bit counter +1; ones counter += chain_in.
REQ-018 SHIFT exit: bit counter reaches CHAIN_LEN -> VERIFY (bit counter cleared); otherwise, after WORD_W bits of the current word -> FETCH.
REQ-019 Words required SHALL be ceil(CHAIN_LEN/WORD_W); unused upper bits of the last word SHALL be discarded and never shifted.
REQ-020 The first bit shifted SHALL end up in the last chain cell; bit CHAIN_LEN-1 of the stream SHALL end up in the first cell.
REQ-021 VERIFY: chain_shift_en=1 for exactly CHAIN_LEN cycles; chain_in=chain_out (recirculate, chain contents restored); a second ones counter += chain_out.
REQ-022 VERIFY exit -> DONE; err=1 iff the load and verify ones counts differ.
REQ-023 DONE: done=1 for one cycle, chain_shift_en=0 -> IDLE.
REQ-024 word_ready SHALL be 0 outside FETCH; a word offered outside FETCH SHALL not be consumed.
REQ-025 start while busy SHALL be ignored.
REQ-026 Counter widths SHALL be clog2(CHAIN_LEN+1); no wrap within a pass.
REQ-027 Total chain_shift_en-high cycles per pass SHALL be exactly 2*CHAIN_LEN, independent of handshake stalls.

Reset
REQ-028 Config_Reset low SHALL immediately force IDLE and set word_ready, chain_in, chain_shift_en, busy, done and err to 0, and clear the PISO and all counters.
REQ-029 Reset asserted mid-pass SHALL abort with no done pulse; after release, the chain holds a partial bitstream and requires a new start.

Structure
REQ-030 Package cgra_cfg_pkg SHALL hold the state enum, the CHAIN_LEN and WORD_W defaults, and the words-required constant function.
REQ-031 One sub-module, cfg_piso (WORD_W parallel-load, serial-out shift register with load/shift enables), SHALL be instantiated.

Verification
REQ-032 CHAIN_LEN=46, words 0xFFFFFFFF, 0x00003FFF, ideal looped 46-bit chain model -> 46 shift cycles, then 46 verify cycles, done, err=0, model = all ones.
REQ-033 Words 0x00000001, 0x00000000 -> model bit at the tail = 1, all others 0; upper 18 bits of word 1 are not shifted; err=0.
REQ-034 Model with one cell stuck-at-0 and ones-count input of 46 -> done with err=1.
REQ-035 word_valid withheld 5 cycles before word 1 -> chain_shift_en=0 and word_ready=1 during the stall; total shift-enable cycles = 92.
REQ-036 Config_Reset low at load bit 20 -> all outputs 0 at once, no done; a later start performs a full clean pass with err=0.
REQ-037 start pulsed during VERIFY -> ignored; exactly one done pulse.
